mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter ADDR_LIMIT, default 32'h0000_3000: first byte address outside data memory; any access at or above it is out of range.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; only the clock and this reset exist.
REQ-004 req  input  1  request strobe from the CPU; sampled only in IDLE.
REQ-005 we  input  1  1 = store, 0 = load.
REQ-006 size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-007 sign_ext  input  1  1 = sign-extend sub-word loads, 0 = zero-extend.
REQ-008 addr  input  32  byte address.
REQ-009 wdata  input  32  store data, right-aligned for sub-word stores.
REQ-010 pc  input  32  PC of the requesting instruction, forwarded for logging.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 err  output  1  one-cycle pulse coincident with done on a rejected request.
REQ-014 rdata  output  32  aligned and extended load result.
REQ-015 dm_we  output  1  word write-enable to data memory.
REQ-016 dm_re  output  1  read-enable to data memory.
REQ-017 dm_addr  output  32  word-aligned address {addr_q[31:2],2'b00}.
REQ-018 dm_wd  output  32  full word written to data memory.
REQ-019 dm_pc  output  32  captured pc, valid whenever dm_we = 1.
REQ-020 dm_rd  input  32  combinational read data from memory, valid in the same cycle as dm_re.

Function
REQ-021 FSM states SHALL be IDLE, RD, WR and RESP.
REQ-022 In IDLE with req = 1, the block SHALL capture we, size, sign_ext, addr, wdata and pc; req is ignored while busy = 1.
REQ-023 The request SHALL be rejected (IDLE->RESP, err = 1, no memory access) on any of: size = 11; halfword with addr[0] = 1; word with addr[1:0] != 00; addr >= ADDR_LIMIT.
REQ-024 A load SHALL sequence IDLE->RD->RESP; in RD, dm_re = 1 and dm_rd is registered.
REQ-025 A word store SHALL sequence IDLE->WR->RESP; in WR, dm_we = 1 and dm_wd = wdata_q.
REQ-026 A byte or halfword store SHALL sequence IDLE->RD->WR->RESP (read-modify-write).
REQ-027 The read-modify-write merge SHALL replace only the addressed lane of the RD-cycle word and preserve the other bytes.
REQ-028 Lanes SHALL be little-endian: byte k at bits [8k+7:8k], k = addr[1:0]; halfword at bits [15:0] when addr[1] = 0 and [31:16] when addr[1] = 1.
REQ-029 Load results SHALL be extracted from the same lane, shifted to bit 0, and sign- or zero-extended per sign_ext; word loads pass through unchanged.
REQ-030 RESP SHALL last exactly one cycle with done = 1, then return to IDLE; a req high in that cycle is not accepted.
REQ-031 rdata SHALL update only on a successful load entering RESP and SHALL hold its value otherwise, including across stores and errors.
REQ-032 Cycles from acceptance edge to done: word load 2, word store 2, sub-word store 3, rejected request 1.
REQ-033 dm_we and dm_re SHALL be 0 outside WR and RD respectively, and never both 1 in the same cycle.
REQ-034 A new request SHALL be accepted on the cycle after RESP; back-to-back operations need no idle gap beyond RESP.

Reset
REQ-035 With reset = 0 at a rising edge, the next state SHALL be IDLE and all captured registers and rdata SHALL become 0.
REQ-036 While reset = 0, dm_we, dm_re, done and err SHALL be forced to 0 combinationally, so a store interrupted in WR issues no write.
REQ-037 After reset, all outputs SHALL be 0 (busy = 0, dm_addr = 0, dm_wd = 0, dm_pc = 0) until the first accepted request.

Verification
REQ-038 Word store then word load: sw 32'hDEADBEEF to 0x10 (pc 0x3000) -> dm_we one cycle with dm_addr 0x10, dm_wd 32'hDEADBEEF, dm_pc 0x3000; next lw 0x10 -> rdata 32'hDEADBEEF, done 2 cycles after acceptance.
REQ-039 Byte store RMW: memory word 0x20 = 32'h11223344; sb 8'hAA to 0x22 -> RD then WR with dm_wd 32'h11AA3344, done 3 cycles after acceptance.
REQ-040 Sub-word loads: word 0x20 = 32'h80FF7F01 -> lb 0x23 sign_ext=1 gives 32'hFFFFFF80; lbu 0x23 gives 32'h00000080; lh 0x22 sign_ext=1 gives 32'hFFFF80FF; lh 0x20 sign_ext=1 gives 32'h00007F01.
REQ-041 Rejections: lw 0x6, sh 0x5, size = 11 and sw 0x3000 -> err = done = 1 one cycle after acceptance, no dm_we/dm_re pulse, rdata unchanged.
REQ-042 Reset mid-RMW: reset = 0 during WR of a sb -> dm_we stays 0, next state IDLE, busy 0, memory word unchanged.
REQ-043 Request while busy: req held high across a lw -> exactly one operation per IDLE acceptance, none taken in RD or RESP.

Source files
------------

// File: rtl/mem_access_if.sv
// -----------------------------------------------------------------------------
// mem_access_if
// Bundles the CPU-side request/response signals and the data-memory port of
// mem_access_unit.
//   CPU side    : req, we, size, sign_ext, addr, wdata, pc  -> unit
//                 busy, done, err, rdata                    <- unit
//   Memory side : dm_we, dm_re, dm_addr, dm_wd, dm_pc       <- unit
//                 dm_rd (combinational read data)           -> unit
// Modports: slave = the access unit, master = the CPU/memory environment.
// -----------------------------------------------------------------------------
interface mem_access_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        dm_we;
    logic        dm_re;
    logic [31:0] dm_addr;
    logic [31:0] dm_wd;
    logic [31:0] dm_pc;
    logic [31:0] dm_rd;

    modport slave (
        input  req, we, size, sign_ext, addr, wdata, pc, dm_rd,
        output busy, done, err, rdata, dm_we, dm_re, dm_addr, dm_wd, dm_pc
    );

    modport master (
        output req, we, size, sign_ext, addr, wdata, pc, dm_rd,
        input  busy, done, err, rdata, dm_we, dm_re, dm_addr, dm_wd, dm_pc
    );
endinterface

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Load/store unit between a CPU and a word-wide data memory. Accepts one
// request at a time, rejects illegal/misaligned/out-of-range accesses, performs
// sub-word stores as read-modify-write and returns aligned, extended loads.
// Ports:
//   clk   - single clock, rising edge
//   reset - synchronous, active-low
//   bus   - mem_access_if.slave (CPU request/response + data-memory port)
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_3000
) (
    input  logic         clk,
    input  logic         reset,
    mem_access_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] rd_q, rd_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        reject;

    // Select the addressed lane, move it to bit 0 and extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  a,
                                                 input logic [1:0]  sz,
                                                 input logic        sx);
        logic [31:0] shifted;
        shifted = word >> {a, 3'b000};
        case (sz)
            SZ_BYTE: load_extract = {{24{sx & shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_extract = {{16{sx & shifted[15]}}, shifted[15:0]};
            default: load_extract = word;
        endcase
    endfunction

    // Replace only the addressed lane of the old word with the new store data.
    function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                                input logic [31:0] data,
                                                input logic [1:0]  a,
                                                input logic [1:0]  sz);
        logic [31:0] mask;
        logic [31:0] lane;
        case (sz)
            SZ_BYTE: begin
                mask = 32'h0000_00FF << {a, 3'b000};
                lane = {24'd0, data[7:0]} << {a, 3'b000};
            end
            SZ_HALF: begin
                mask = 32'h0000_FFFF << {a[1], 4'b0000};
                lane = {16'd0, data[15:0]} << {a[1], 4'b0000};
            end
            default: begin
                mask = 32'hFFFF_FFFF;
                lane = data;
            end
        endcase
        store_merge = (old_word & ~mask) | (lane & mask);
    endfunction

    always_comb begin
        reject = (bus.size == 2'b11)
              || (bus.size == SZ_HALF && bus.addr[0])
              || (bus.size == SZ_WORD && bus.addr[1:0] != 2'b00)
              || (bus.addr >= ADDR_LIMIT);
    end

    // NOTE: every next-state variable gets its hold value first so no path
    // through the case leaves one unassigned (which would infer a latch).
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        sign_d  = sign_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        pc_d    = pc_q;
        rd_d    = rd_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    we_d    = bus.we;
                    size_d  = bus.size;
                    sign_d  = bus.sign_ext;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    pc_d    = bus.pc;
                    err_d   = reject;
                    if (reject)                    state_d = RESP;
                    else if (!bus.we)              state_d = RD;
                    else if (bus.size == SZ_WORD)  state_d = WR;
                    else                           state_d = RD;  // RMW store
                end
            end
            RD: begin
                rd_d = bus.dm_rd;
                if (we_q) begin
                    state_d = WR;
                end else begin
                    rdata_d = load_extract(bus.dm_rd, addr_q[1:0], size_q, sign_q);
                    state_d = RESP;
                end
            end
            WR:      state_d = RESP;
            default: state_d = IDLE;  // RESP lasts one cycle
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the reset
    // clears every captured register so outputs read 0 until the first request.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sign_q  <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            pc_q    <= 32'd0;
            rd_q    <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            pc_q    <= pc_d;
            rd_q    <= rd_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Strobes are gated by reset combinationally: a store caught in WR by a
    // reset must not reach memory.
    assign bus.busy    = (state_q != IDLE);
    assign bus.dm_re   = reset && (state_q == RD);
    assign bus.dm_we   = reset && (state_q == WR);
    assign bus.done    = reset && (state_q == RESP);
    assign bus.err     = reset && (state_q == RESP) && err_q;
    assign bus.rdata   = rdata_q;
    assign bus.dm_addr = {addr_q[31:2], 2'b00};
    assign bus.dm_wd   = store_merge(rd_q, wdata_q, addr_q[1:0], size_q);
    assign bus.dm_pc   = pc_q;

endmodule
